pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. Every cycle it computes the hold (`enb*`) and clear (`flash*`) controls for the F/D/E/M/W stage registers. It resolves load-use hazards, branch/jump redirects, instruction-fetch waits and data-memory waits, and tracks stale fetches after a redirect. It also keeps a stall-cycle counter and a sticky data-memory timeout flag.

---
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage core.
// Produces per-stage hold (enb*) and clear (flash*) controls combinationally,
// tracks stale instruction fetches after a redirect (RUN/DROP), counts stall
// cycles and flags data-memory timeouts.
//
// Control handshake: the stage controls are valid in the same cycle as the
// hazard inputs and are consumed by the stage registers at the next rising
// edge; there is no valid/ready pair and no registered latency.
module pipe_hazard_ctrl #(
  parameter int TMO_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic             use_rs1D,
  input  logic             use_rs2D,
  input  logic [4:0]       rdE,
  input  logic             we_regE,
  input  logic             mux9E,
  input  logic             redirectE,
  input  logic             imem_ackF,
  input  logic             dmem_reqM,
  input  logic             dmem_ackM,
  output logic             enbF,
  output logic             enbD,
  output logic             enbE,
  output logic             enbM,
  output logic             enbW,
  output logic             flashD,
  output logic             flashE,
  output logic             flashM,
  output logic             flashW,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_err,
  output logic             state_dbg
);

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [TMO_W-1:0] wait_cnt;
  logic             memstall;
  logic             redir;
  logic             lduse;
  logic             fwait;

  // Hazard detectors, before priority is applied.
  assign memstall = dmem_reqM & ~dmem_ackM;
  assign redir    = redirectE;
  assign lduse    = mux9E & we_regE & (rdE != 5'd0) &
                    ((use_rs1D & (rs1D == rdE)) | (use_rs2D & (rs2D == rdE)));
  assign fwait    = ~imem_ackF | (state == DROP);

  // 1 while a pre-redirect fetch is still outstanding.
  assign state_dbg = (state == DROP);

  // State register for the stale-fetch tracker.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // Prioritised stage controls and next-state logic.
  always_comb begin
    enbF     = 1'b0;
    enbD     = 1'b0;
    enbE     = 1'b0;
    enbM     = 1'b0;
    enbW     = 1'b0;
    flashD   = 1'b0;
    flashE   = 1'b0;
    flashM   = 1'b0;
    flashW   = 1'b0;
    state_nx = state;
    if (rst) begin
      flashD   = 1'b1;
      flashE   = 1'b1;
      flashM   = 1'b1;
      flashW   = 1'b1;
      state_nx = RUN;
    end else begin
      if (memstall) begin
        enbF   = 1'b1;
        enbD   = 1'b1;
        enbE   = 1'b1;
        enbM   = 1'b1;
        flashW = 1'b1;
      end else if (redir) begin
        flashD = 1'b1;
        flashE = 1'b1;
      end else if (lduse) begin
        enbF   = 1'b1;
        enbD   = 1'b1;
        flashE = 1'b1;
      end else if (fwait) begin
        enbF   = 1'b1;
        flashD = 1'b1;
      end
      // An ack in DROP always retires the stale fetch, whichever rule won.
      if (state == DROP) begin
        if (imem_ackF) state_nx = RUN;
      end else if (!memstall && redir && !imem_ackF) begin
        state_nx = DROP;
      end
    end
  end

  // Memory-wait timer, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (memstall) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == '1) mem_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (enbF && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle rule
// vectors plus hand-written multi-cycle sequences, checked via an expected
// queue of packed stage controls.
module tb_pipe_hazard_ctrl;

  localparam int TMO_W = 3;
  localparam int CNT_W = 4;

  // Packed control order: {enbF,enbD,enbE,enbM,enbW,flashD,flashE,flashM,flashW}
  localparam logic [8:0] C_IDLE  = 9'b00000_0000;
  localparam logic [8:0] C_RST   = 9'b00000_1111;
  localparam logic [8:0] C_MEM   = 9'b11110_0001;
  localparam logic [8:0] C_REDIR = 9'b00000_1100;
  localparam logic [8:0] C_LDU   = 9'b11000_0100;
  localparam logic [8:0] C_FWAIT = 9'b10000_1000;

  logic             clk;
  logic             rst;
  logic [4:0]       rs1D;
  logic [4:0]       rs2D;
  logic             use_rs1D;
  logic             use_rs2D;
  logic [4:0]       rdE;
  logic             we_regE;
  logic             mux9E;
  logic             redirectE;
  logic             imem_ackF;
  logic             dmem_reqM;
  logic             dmem_ackM;
  logic             enbF, enbD, enbE, enbM, enbW;
  logic             flashD, flashE, flashM, flashW;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_err;
  logic             state_dbg;

  typedef struct {
    string      name;
    logic       rst;
    logic       u1;
    logic [4:0] rs1;
    logic       u2;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
    logic       m9;
    logic       redir;
    logic       iack;
    logic       dreq;
    logic       dack;
    logic [8:0] exp;
  } vec_t;

  vec_t       vecs[15];
  logic [8:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  pipe_hazard_ctrl #(.TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
    .rdE(rdE), .we_regE(we_regE), .mux9E(mux9E), .redirectE(redirectE),
    .imem_ackF(imem_ackF), .dmem_reqM(dmem_reqM), .dmem_ackM(dmem_ackM),
    .enbF(enbF), .enbD(enbD), .enbE(enbE), .enbM(enbM), .enbW(enbW),
    .flashD(flashD), .flashE(flashE), .flashM(flashM), .flashW(flashW),
    .stall_cnt(stall_cnt), .mem_err(mem_err), .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input string n, input logic u1, input logic [4:0] rs1,
                              input logic u2, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic we, input logic m9, input logic redir,
                              input logic iack, input logic dreq, input logic dack,
                              input logic [8:0] e);
    vec_t v;
    v.name = n; v.rst = 1'b0; v.u1 = u1; v.rs1 = rs1; v.u2 = u2; v.rs2 = rs2;
    v.rd = rd; v.we = we; v.m9 = m9; v.redir = redir; v.iack = iack;
    v.dreq = dreq; v.dack = dack; v.exp = e;
    return v;
  endfunction

  function automatic vec_t idle(input string n, input logic [8:0] e);
    return mk(n, 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 1, 0, 0, e);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs, record the expected controls, compare at the
  // falling edge, then advance past the rising edge.
  task automatic cyc(input vec_t v);
    logic [8:0] e;
    rst = v.rst; use_rs1D = v.u1; rs1D = v.rs1; use_rs2D = v.u2; rs2D = v.rs2;
    rdE = v.rd; we_regE = v.we; mux9E = v.m9; redirectE = v.redir;
    imem_ackF = v.iack; dmem_reqM = v.dreq; dmem_ackM = v.dack;
    exp_q.push_back(v.exp);
    @(negedge clk);
    e = exp_q.pop_front();
    chk(v.name, {23'd0, enbF, enbD, enbE, enbM, enbW, flashD, flashE, flashM, flashW},
        {23'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vec_t v;
    v = idle("reset_ctrl", C_RST);
    v.rst = 1'b1;
    cyc(v);
    chk("reset_state", {31'd0, state_dbg}, 32'd0);
    chk("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("reset_mem_err", {31'd0, mem_err}, 32'd0);
  endtask

  initial begin
    vec_t v;
    // Rule vectors, all applied in RUN with no transition into DROP.
    //             name          u1 rs1  u2 rs2  rd   we m9 rd iak dq dk exp
    vecs[0]  = mk("idle",        1, 5'd3, 1, 5'd4, 5'd9, 1, 1, 0, 1, 0, 0, C_IDLE);
    vecs[1]  = mk("lduse_rs1",   1, 5'd5, 0, 5'd0, 5'd5, 1, 1, 0, 1, 0, 0, C_LDU);
    vecs[2]  = mk("lduse_rs2",   0, 5'd1, 1, 5'd9, 5'd9, 1, 1, 0, 1, 0, 0, C_LDU);
    vecs[3]  = mk("lduse_rd0",   1, 5'd0, 1, 5'd0, 5'd0, 1, 1, 0, 1, 0, 0, C_IDLE);
    vecs[4]  = mk("lduse_nowe",  1, 5'd5, 0, 5'd0, 5'd5, 0, 1, 0, 1, 0, 0, C_IDLE);
    vecs[5]  = mk("lduse_alu",   1, 5'd5, 0, 5'd0, 5'd5, 1, 0, 0, 1, 0, 0, C_IDLE);
    vecs[6]  = mk("lduse_nouse", 0, 5'd5, 0, 5'd5, 5'd5, 1, 1, 0, 1, 0, 0, C_IDLE);
    vecs[7]  = mk("memstall",    0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 1, 1, 0, C_MEM);
    vecs[8]  = mk("mem_ack",     0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 1, 1, 1, C_IDLE);
    vecs[9]  = mk("redir",       0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 1, 1, 0, 0, C_REDIR);
    vecs[10] = mk("fwait",       0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 0, 0, 0, C_FWAIT);
    vecs[11] = mk("redir_lduse", 1, 5'd6, 0, 5'd0, 5'd6, 1, 1, 1, 1, 0, 0, C_REDIR);
    vecs[12] = mk("mem_redir",   0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 1, 1, 1, 0, C_MEM);
    vecs[13] = mk("lduse_fwait", 0, 5'd0, 1, 5'd8, 5'd8, 1, 1, 0, 0, 0, 0, C_LDU);
    vecs[14] = mk("mem_lduse",   1, 5'd2, 0, 5'd0, 5'd2, 1, 1, 0, 1, 1, 0, C_MEM);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i]);
      chk({vecs[i].name, "_state"}, {31'd0, state_dbg}, 32'd0);
    end

    // Load-use: one bubble, then the load has moved on.
    do_reset();
    cyc(mk("ldu_seq_c1", 0, 5'd0, 1, 5'd5, 5'd5, 1, 1, 0, 1, 0, 0, C_LDU));
    cyc(mk("ldu_seq_c2", 0, 5'd0, 1, 5'd5, 5'd11, 1, 0, 0, 1, 0, 0, C_IDLE));
    chk("ldu_seq_stall_cnt", {28'd0, stall_cnt}, 32'd1);
    cyc(mk("ldu_rd0_seq", 0, 5'd0, 1, 5'd0, 5'd0, 1, 1, 0, 1, 0, 0, C_IDLE));
    chk("ldu_rd0_stall_cnt", {28'd0, stall_cnt}, 32'd1);

    // Memory wait of 3 cycles, released on the ack cycle.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(mk("mem3_wait", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 1, 1, 0, C_MEM));
    cyc(mk("mem3_ack", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 1, 1, 1, C_IDLE));
    chk("mem3_stall_cnt", {28'd0, stall_cnt}, 32'd3);
    chk("mem3_mem_err", {31'd0, mem_err}, 32'd0);

    // Redirect with fetch outstanding; ack two cycles later.
    do_reset();
    cyc(mk("rd_redir", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 1, 0, 0, 0, C_REDIR));
    chk("rd_state_drop", {31'd0, state_dbg}, 32'd1);
    cyc(mk("rd_wait", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 0, 0, 0, C_FWAIT));
    chk("rd_state_wait", {31'd0, state_dbg}, 32'd1);
    cyc(mk("rd_stale_ack", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 1, 0, 0, C_FWAIT));
    chk("rd_state_run", {31'd0, state_dbg}, 32'd0);
    cyc(idle("rd_resume", C_IDLE));
    chk("rd_stall_cnt", {28'd0, stall_cnt}, 32'd2);
    // A second redirect while in DROP keeps DROP.
    cyc(mk("rd2_redir", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 1, 0, 0, 0, C_REDIR));
    cyc(mk("rd2_redir_drop", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 1, 0, 0, 0, C_REDIR));
    chk("rd2_state_drop", {31'd0, state_dbg}, 32'd1);
    // Ack under MEMSTALL in DROP still retires the stale fetch.
    cyc(mk("rd2_mem_ack", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 1, 1, 0, C_MEM));
    chk("rd2_state_run", {31'd0, state_dbg}, 32'd0);

    // Timeout: 9 wait cycles with TMO_W=3, flag rises at the 8th edge.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cyc(mk("tmo_wait", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 1, 1, 0, C_MEM));
      chk($sformatf("tmo_mem_err_edge%0d", i), {31'd0, mem_err}, (i >= 8) ? 32'd1 : 32'd0);
    end
    cyc(mk("tmo_ack", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 1, 1, 1, C_IDLE));
    chk("tmo_sticky", {31'd0, mem_err}, 32'd1);
    chk("tmo_stall_cnt", {28'd0, stall_cnt}, 32'd9);
    // Stall counter saturates at 15.
    for (int i = 0; i < 10; i++) cyc(mk("sat_fwait", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 0, 0, 0, C_FWAIT));
    chk("sat_stall_cnt", {28'd0, stall_cnt}, 32'd15);
    do_reset();

    // Reset mid-MEMSTALL while in DROP.
    cyc(mk("rm_redir", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 1, 0, 0, 0, C_REDIR));
    cyc(mk("rm_mem", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 0, 1, 0, C_MEM));
    chk("rm_state_drop", {31'd0, state_dbg}, 32'd1);
    v = mk("rm_rst_ctrl", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 0, 1, 0, C_RST);
    v.rst = 1'b1;
    cyc(v);
    chk("rm_state", {31'd0, state_dbg}, 32'd0);
    chk("rm_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("rm_mem_err", {31'd0, mem_err}, 32'd0);
    // Wait timer also cleared: 7 further waits must not raise the flag.
    for (int i = 0; i < 7; i++) cyc(mk("rm_wait", 0, 5'd0, 0, 5'd0, 5'd7, 0, 0, 0, 1, 1, 0, C_MEM));
    chk("rm_wait_cleared", {31'd0, mem_err}, 32'd0);

    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
